// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/lap sequencer for a two-digit BCD seconds stopwatch.
// Detects button rising edges, gates the tick prescaler, owns the BCD count and the
// lap-frozen display registers, and drives the blank request for the 7-segment stage.
// Optional build macro: STOPWATCH_AUTOSTOP_EN - stop at MAX_COUNT (RUN->PAUSE) instead
// of wrapping to 0; a start press is then ignored until clear or disable.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       tick,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic       blank,
    output logic       running,
    output logic       done
);

    localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0]    MAX_ONES = 4'(MAX_COUNT % 10);
`ifdef STOPWATCH_AUTOSTOP_EN
    localparam logic [3:0]    PEN_TENS = 4'((MAX_COUNT - 1) / 10);
    localparam logic [3:0]    PEN_ONES = 4'((MAX_COUNT - 1) % 10);
`endif

    typedef enum logic [1:0] {StOff, StIdle, StRun, StPause} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    cnt_tens_q, cnt_tens_d, cnt_ones_q, cnt_ones_d;
    logic [3:0]    lap_tens_q, lap_tens_d, lap_ones_q, lap_ones_d;
    logic          lap_hold_q, lap_hold_d;
    logic          tick_q, tick_d, done_q, done_d;
    logic          btn_start_q, btn_clear_q, btn_lap_q;

    logic          start_edge, clear_edge, lap_edge;
    logic          at_max, resume_ok;
    logic [3:0]    inc_tens, inc_ones;

    assign start_edge = btn_start & ~btn_start_q;
    assign clear_edge = btn_clear & ~btn_clear_q;
    assign lap_edge   = btn_lap & ~btn_lap_q;

    assign at_max = (cnt_tens_q == MAX_TENS) && (cnt_ones_q == MAX_ONES);

    // A stopped-at-terminal count must not be resumed; without autostop any pause resumes.
`ifdef STOPWATCH_AUTOSTOP_EN
    assign resume_ok = ~at_max;
`else
    assign resume_ok = 1'b1;
`endif

    // BCD +1 of the live count; only used when the count is below MAX_COUNT.
    always_comb begin
        inc_tens = cnt_tens_q;
        inc_ones = cnt_ones_q + 4'd1;
        if (cnt_ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = cnt_tens_q + 4'd1;
        end
    end

    // Next-state: enable override, then clear, then prescaler/count, start and lap actions.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        cnt_tens_d = cnt_tens_q;
        cnt_ones_d = cnt_ones_q;
        lap_tens_d = lap_tens_q;
        lap_ones_d = lap_ones_q;
        lap_hold_d = lap_hold_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        if (!en) begin
            state_d    = StOff;
            pre_d      = '0;
            cnt_tens_d = 4'd0;
            cnt_ones_d = 4'd0;
            lap_hold_d = 1'b0;
        end else if (state_q == StOff) begin
            state_d = StIdle;
        end else if (clear_edge) begin
            state_d    = StIdle;
            pre_d      = '0;
            cnt_tens_d = 4'd0;
            cnt_ones_d = 4'd0;
            lap_hold_d = 1'b0;
        end else begin
            if (state_q == StRun) begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
`ifdef STOPWATCH_AUTOSTOP_EN
                    if ((cnt_tens_q == PEN_TENS) && (cnt_ones_q == PEN_ONES)) begin
                        cnt_tens_d = MAX_TENS;
                        cnt_ones_d = MAX_ONES;
                        done_d     = 1'b1;
                        state_d    = StPause;
                    end else begin
                        cnt_tens_d = inc_tens;
                        cnt_ones_d = inc_ones;
                    end
`else
                    if (at_max) begin
                        cnt_tens_d = 4'd0;
                        cnt_ones_d = 4'd0;
                        done_d     = 1'b1;
                    end else begin
                        cnt_tens_d = inc_tens;
                        cnt_ones_d = inc_ones;
                    end
`endif
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end

            if (start_edge) begin
                if (state_q == StRun) begin
                    state_d = StPause;
                end else if (state_q == StIdle) begin
                    state_d = StRun;
                    pre_d   = '0;
                end else if (resume_ok) begin
                    state_d = StRun;
                end
            end

            // Capture uses the pre-increment count so a coincident tick does not leak in.
            if (lap_edge) begin
                if (lap_hold_q) begin
                    lap_hold_d = 1'b0;
                end else if (state_q == StRun) begin
                    lap_tens_d = cnt_tens_q;
                    lap_ones_d = cnt_ones_q;
                    lap_hold_d = 1'b1;
                end
            end
        end
    end

    // State registers; edge-detect samples load on reset so a held button cannot fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StOff;
            pre_q       <= '0;
            cnt_tens_q  <= 4'd0;
            cnt_ones_q  <= 4'd0;
            lap_tens_q  <= 4'd0;
            lap_ones_q  <= 4'd0;
            lap_hold_q  <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_tens_q  <= cnt_tens_d;
            cnt_ones_q  <= cnt_ones_d;
            lap_tens_q  <= lap_tens_d;
            lap_ones_q  <= lap_ones_d;
            lap_hold_q  <= lap_hold_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
        end
        btn_start_q <= btn_start;
        btn_clear_q <= btn_clear;
        btn_lap_q   <= btn_lap;
    end

    assign tick      = tick_q;
    assign done      = done_q;
    assign cnt_tens  = cnt_tens_q;
    assign cnt_ones  = cnt_ones_q;
    assign disp_tens = lap_hold_q ? lap_tens_q : cnt_tens_q;
    assign disp_ones = lap_hold_q ? lap_ones_q : cnt_ones_q;
    assign blank     = (state_q == StOff);
    assign running   = (state_q == StRun);

endmodule
